// File: rtl/addroundkey_stream.sv
// addroundkey_stream: registered AddRoundKey stage with a round-key bank,
// valid/ready streaming through an output register plus one skid entry,
// a per-beat bypass and sticky out-of-range index detection.
module addroundkey_stream #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned NUM_KEYS = 11,
  parameter int unsigned IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_we,
  input  logic [IDX_W-1:0]  key_waddr,
  input  logic [DATA_W-1:0] key_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              err_idx,
  input  logic              err_clr
);

  localparam int unsigned CMP_W = IDX_W + 1;
  localparam logic [CMP_W-1:0] NUM_KEYS_CMP = CMP_W'(NUM_KEYS);

  logic [DATA_W-1:0] bank [NUM_KEYS];
  logic [DATA_W-1:0] key_sel_c;
  logic [DATA_W-1:0] beat_data_c;
  logic              idx_bad_c;
  logic              waddr_bad_c;
  logic              accept_c;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [IDX_W-1:0]  skid_idx;

  assign accept_c    = in_valid && in_ready;
  assign idx_bad_c   = {1'b0, in_idx} >= NUM_KEYS_CMP;
  assign waddr_bad_c = {1'b0, key_waddr} >= NUM_KEYS_CMP;

  // Key lookup; an index past the bank matches no slot and yields an all-zero key.
  always_comb begin
    key_sel_c = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (in_idx == IDX_W'(i)) key_sel_c = bank[i];
    end
  end

  // Whole-word XOR is the bytewise XOR, independent of byte ordering.
  assign beat_data_c = in_bypass ? in_data : (in_data ^ key_sel_c);

  // Key bank writes; the beat in the same cycle still sees the old key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) bank[i] <= '0;
    end else if (key_we) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        if (key_waddr == IDX_W'(i)) bank[i] <= key_wdata;
      end
    end
  end

  // Output register plus skid entry; in_ready is the registered "skid empty" flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_idx   <= '0;
      in_ready   <= 1'b1;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_idx    <= skid_idx;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (accept_c) begin
        out_valid <= 1'b1;
        out_data  <= beat_data_c;
        out_idx   <= in_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept_c) begin
      skid_valid <= 1'b1;
      skid_data  <= beat_data_c;
      skid_idx   <= in_idx;
      in_ready   <= 1'b0;
    end
  end

  // Sticky error flag; a new error in the clear cycle keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_idx <= 1'b0;
    end else if ((key_we && waddr_bad_c) || (accept_c && !in_bypass && idx_bad_c)) begin
      err_idx <= 1'b1;
    end else if (err_clr) begin
      err_idx <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addroundkey_stream.sv
// Bench for addroundkey_stream: directed FIPS/collision/bypass/backpressure/reset
// cases with literal expectations, then a randomized run against a queue model.
module tb_addroundkey_stream;

  localparam int unsigned DW = 128;
  localparam int unsigned NK = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_we;
  logic [3:0]    key_waddr;
  logic [DW-1:0] key_wdata;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [3:0]    in_idx;
  logic          in_bypass;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [3:0]    out_idx;
  logic          err_idx;
  logic          err_clr;

  int errors = 0;
  int checks = 0;

  addroundkey_stream #(.DATA_W(DW), .NUM_KEYS(NK), .IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_idx(in_idx), .in_bypass(in_bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .err_idx(err_idx), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: key array, FIFO of expected beats (max two in flight), error flag.
  typedef struct {
    logic [DW-1:0] d;
    logic [3:0]    i;
  } beat_t;

  beat_t         q[$];
  beat_t         popped;
  beat_t         nb;
  logic [DW-1:0] m_keys [16];
  logic          m_err = 1'b0;
  logic          m_acc;
  logic          m_set;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model update on each rising edge from the inputs and model state alone.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < 16; i++) m_keys[i] = '0;
      m_err = 1'b0;
    end else begin
      m_acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) popped = q.pop_front();
      if (m_acc) begin
        nb.i = in_idx;
        if (in_bypass) nb.d = in_data;
        else if (in_idx < 4'(NK)) nb.d = in_data ^ m_keys[in_idx];
        else nb.d = in_data;
        q.push_back(nb);
      end
      if (key_we && key_waddr < 4'(NK)) m_keys[key_waddr] = key_wdata;
      m_set = (key_we && key_waddr >= 4'(NK)) || (m_acc && !in_bypass && in_idx >= 4'(NK));
      if (m_set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
      chk("in_ready", DW'(in_ready), DW'(q.size() < 2));
      chk("err_idx", DW'(err_idx), DW'(m_err));
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_idx", DW'(out_idx), DW'(q[0].i));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    key_we = 1'b0; key_waddr = '0; key_wdata = '0;
    in_valid = 1'b0; in_data = '0; in_idx = '0; in_bypass = 1'b0;
    err_clr = 1'b0;
  endtask

  logic [DW-1:0] keys [NK];
  logic [DW-1:0] held;
  logic [DW-1:0] x;
  int            acc_cnt;

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    repeat (3) step();
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_idx", DW'(out_idx), '0);
    chk("rst_err_idx", DW'(err_idx), '0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", DW'(in_ready), DW'(1));

    // FIPS-197 round 0
    key_we = 1'b1; key_waddr = 4'd0; key_wdata = 128'h000102030405060708090a0b0c0d0e0f;
    step();
    idle_inputs();
    in_valid = 1'b1; in_idx = 4'd0; in_data = 128'h00112233445566778899aabbccddeeff;
    step();
    idle_inputs();
    chk("fips_valid", DW'(out_valid), DW'(1));
    chk("fips_data", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("fips_idx", DW'(out_idx), '0);
    step();

    // Back-to-back: distinct keys in all slots, 11 beats idx 0..10
    for (int k = 0; k < int'(NK); k++) begin
      keys[k] = rnd128();
      key_we = 1'b1; key_waddr = 4'(k); key_wdata = keys[k];
      step();
    end
    idle_inputs();
    for (int k = 0; k < int'(NK); k++) begin
      chk("b2b_in_ready", DW'(in_ready), DW'(1));
      in_valid = 1'b1; in_idx = 4'(k); x = rnd128(); in_data = x;
      step();
      chk("b2b_out_valid", DW'(out_valid), DW'(1));
      chk("b2b_out_data", out_data, x ^ keys[k]);
    end
    idle_inputs();
    step();

    // Backpressure: 4 stalled cycles with continuous valid
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (in_ready) acc_cnt++;
      in_valid = 1'b1; in_idx = 4'($urandom_range(0, NK - 1)); in_data = rnd128();
      step();
      if (k == 0) held = out_data;
      else chk("bp_hold", out_data, held);
      if (k >= 1) chk("bp_in_ready_low", DW'(in_ready), '0);
    end
    chk("bp_accepts", DW'(acc_cnt), DW'(2));
    idle_inputs();
    out_ready = 1'b1;
    repeat (3) step();

    // Write/read collision on slot 3
    key_we = 1'b1; key_waddr = 4'd3; key_wdata = {16{8'hAA}};
    step();
    key_wdata = {16{8'h55}};
    in_valid = 1'b1; in_idx = 4'd3; in_data = '0;
    step();
    chk("coll_old_key", out_data, {16{8'hAA}});
    key_we = 1'b0;
    step();
    chk("coll_new_key", out_data, {16{8'h55}});
    idle_inputs();
    step();

    // Bypass then bad index
    in_valid = 1'b1; in_bypass = 1'b1; in_idx = 4'd2;
    in_data = 128'h123456789abcdef0fedcba9876543210;
    step();
    chk("bypass_data", out_data, 128'h123456789abcdef0fedcba9876543210);
    chk("bypass_no_err", DW'(err_idx), '0);
    in_bypass = 1'b0; in_idx = 4'd12; in_data = 128'hdeadbeef00112233cafef00d44556677;
    step();
    chk("badidx_data", out_data, 128'hdeadbeef00112233cafef00d44556677);
    chk("badidx_err", DW'(err_idx), DW'(1));
    idle_inputs();
    repeat (3) step();
    chk("err_sticky", DW'(err_idx), DW'(1));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", DW'(err_idx), '0);
    // clear and new error together: set wins
    err_clr = 1'b1; key_we = 1'b1; key_waddr = 4'd14; key_wdata = rnd128();
    step();
    idle_inputs();
    chk("err_set_wins", DW'(err_idx), DW'(1));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Mid-stream reset with output and skid full (slot 0 holds a nonzero key)
    out_ready = 1'b0;
    in_valid = 1'b1; in_idx = 4'd0;
    in_data = rnd128(); step();
    in_data = rnd128(); step();
    idle_inputs();
    chk("mr_full_in_ready", DW'(in_ready), '0);
    chk("mr_full_valid", DW'(out_valid), DW'(1));
    rst = 1'b1;
    #1;
    chk("mr_async_valid", DW'(out_valid), '0);
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mr_in_ready", DW'(in_ready), DW'(1));
    x = rnd128();
    in_valid = 1'b1; in_idx = 4'd0; in_data = x;
    step();
    idle_inputs();
    chk("mr_key_zero", out_data, x);
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rnd128();
      in_idx    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(NK, 15)) : 4'($urandom_range(0, NK - 1));
      in_bypass = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      key_we    = ($urandom_range(0, 7) == 0);
      key_waddr = 4'($urandom_range(0, 15));
      key_wdata = rnd128();
      err_clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    idle_inputs();
    out_ready = 1'b1;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
